rf_wb_arb: RTL and testbench
============================

RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 3, range 1..7: consecutive cycles wb1 may wait before it is granted by force.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wb0_valid  input  1  pipeline writeback request.
REQ-005 wb0_ready  output  1  wb0 granted this cycle.
REQ-006 wb0_addr  input  5  wb0 destination register.
REQ-007 wb0_data  input  32  wb0 write data.
REQ-008 wb1_valid  input  1  multi-cycle-unit writeback request (mul/div/load return).
REQ-009 wb1_ready  output  1  wb1 granted this cycle.
REQ-010 wb1_addr  input  5  wb1 destination register.
REQ-011 wb1_data  input  32  wb1 write data.
REQ-012 regw  output  1  register file write enable.
REQ-013 A3  output  5  register file write address.
REQ-014 WD  output  32  register file write data.
REQ-015 issue_valid  input  1  multi-cycle op issued; marks issue_addr pending.
REQ-016 issue_addr  input  5  destination of issued op.
REQ-017 issue_ready  output  1  issue accepted.
REQ-018 rs_addr, rt_addr  input  5 each  hazard query addresses.
REQ-019 rs_busy, rt_busy  output  1 each  queried register has a pending wb1 write.

Function
REQ-020 Handshake: transfer on valid&&ready; requester holds valid, addr, data stable until ready; ready is combinational from state and valids.
REQ-021 FSM states NORM and FORCE; at most one of wb0_ready, wb1_ready is high in any cycle.
REQ-022 NORM: wb0_ready=wb0_valid; wb1_ready=wb1_valid&&!wb0_valid.
REQ-023 FORCE: wb1_ready=wb1_valid; wb0_ready=0.
REQ-024 wait_cnt (3 bits): increments each cycle wb1_valid&&!wb1_ready in NORM, saturating at 7; cleared on wb1 transfer or when wb1_valid is low.
REQ-025 NORM->FORCE on the edge where wait_cnt+1 reaches STARVE_LIMIT while wb1 is still waiting; FORCE->NORM after the wb1 transfer, or if wb1_valid is low in FORCE; wait_cnt cleared on either exit.
REQ-026 Write port combinational from grant: regw=1, A3, WD = granted requester's addr/data; with no grant regw=0, A3=0, WD=0.
REQ-027 Grant to address 0 completes the handshake but drives regw=0.

Configuration
REQ-028 Macro RF_WB_SCOREBOARD_EN compiles in a 32-bit busy vector.
REQ-029 With it: issue_valid&&issue_ready sets busy[issue_addr]; wb1 transfer clears busy[wb1_addr]; same-cycle set and clear of one register leaves it set; issue_addr 0 never sets.
REQ-030 With it: issue_ready = !busy[issue_addr] (WAW block); rs_busy = busy[rs_addr] && !(wb1 transfer to rs_addr this cycle); rt_busy likewise; address 0 never busy.
REQ-031 Without it: no busy storage; issue_ready=1; rs_busy=rt_busy=0; arbitration unchanged.

Reset
REQ-032 rst synchronously sets state NORM, wait_cnt 0, busy vector 0; in-flight requests are not retained and are re-arbitrated from NORM.
REQ-033 While rst is high, all outputs are 0 except issue_ready, which is 1.

Verification
REQ-034 wb0 only, addr 5, data 0xDEADBEEF -> same cycle wb0_ready=1, regw=1, A3=5, WD=0xDEADBEEF.
REQ-035 wb0 and wb1 both continuously valid, STARVE_LIMIT=3 -> wb0 granted cycles 0-2; wb1 granted cycle 3 with wb0_ready=0; wb0 granted again cycle 4.
REQ-036 wb1 addr 0, data 0x1234, alone -> wb1_ready=1, regw=0.
REQ-037 Scoreboard: issue addr 8, then rs_addr=8 -> rs_busy=1; second issue to 8 -> issue_ready=0; wb1 transfer to 8 -> rs_busy=0 that cycle; issue_ready=1 next cycle.
REQ-038 Same-cycle issue addr 9 and wb1 transfer to 9 -> busy[9]=1 next cycle.
REQ-039 rst asserted in FORCE with busy[8]=1 -> next cycle NORM, wait_cnt 0, rs_busy=0 for rs_addr=8, regw=0.

Source files
------------

// File: rtl/rf_wb_arb.sv
// rf_wb_arb -- register-file writeback arbiter.
//
// Two writeback sources share one register-file write port:
//   wb0 : single-cycle pipeline writeback, normally has priority.
//   wb1 : multi-cycle unit return (mul/div/load). It is granted by force once
//         it has waited STARVE_LIMIT consecutive cycles.
// Grants, ready and the write port are all combinational from state + valids.
//
// Optional feature (macro RF_WB_SCOREBOARD_EN): a 32-entry pending-write
// scoreboard. Issue of a multi-cycle op marks its destination busy. A wb1
// transfer clears that mark. Hazard queries on rs/rt and a WAW issue block
// come from it. Without the macro: issue_ready=1 and rs_busy=rt_busy=0.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   wb0_valid/ready/addr/data        pipeline writeback handshake
//   wb1_valid/ready/addr/data        multi-cycle writeback handshake
//   regw, A3, WD                     register file write port
//   issue_valid/addr, issue_ready    multi-cycle issue (marks pending)
//   rs_addr, rt_addr, rs_busy, rt_busy   hazard queries
module rf_wb_arb #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb0_valid,
    output logic        wb0_ready,
    input  logic [4:0]  wb0_addr,
    input  logic [31:0] wb0_data,
    input  logic        wb1_valid,
    output logic        wb1_ready,
    input  logic [4:0]  wb1_addr,
    input  logic [31:0] wb1_data,
    output logic        regw,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    output logic        issue_ready,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        rs_busy,
    output logic        rt_busy
);

    localparam logic [0:0] NORM  = 1'b0;
    localparam logic [0:0] FORCE = 1'b1;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [0:0] state_q, state_d;
    logic [2:0] wait_cnt_q, wait_cnt_d;
    logic       g0, g1;

    // Raw grants from state; masked by rst so every output is quiet in reset.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (state_q == FORCE) begin
            g1 = wb1_valid;
        end else begin
            g0 = wb0_valid;
            g1 = wb1_valid && !wb0_valid;
        end
    end

    assign wb0_ready = g0 && !rst;
    assign wb1_ready = g1 && !rst;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (state_q == FORCE) begin
            // In FORCE wb1_ready follows wb1_valid, so this cycle is either
            // the wb1 transfer or wb1 has gone away: leave either way.
            state_d    = NORM;
            wait_cnt_d = 3'd0;
        end else if (wb1_valid && !wb1_ready) begin
            if ({1'b0, wait_cnt_q} + 4'd1 >= LIMIT)
                state_d = FORCE;
            wait_cnt_d = (wait_cnt_q == 3'd7) ? 3'd7 : wait_cnt_q + 3'd1;
        end else begin
            wait_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= NORM;
            wait_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Write port. A grant to r0 still completes the handshake but never writes.
    always_comb begin
        regw = 1'b0;
        A3   = 5'd0;
        WD   = 32'd0;
        if (wb0_ready) begin
            regw = (wb0_addr != 5'd0);
            A3   = wb0_addr;
            WD   = wb0_data;
        end else if (wb1_ready) begin
            regw = (wb1_addr != 5'd0);
            A3   = wb1_addr;
            WD   = wb1_data;
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;
    logic        wb1_xfer, issue_fire;

    assign wb1_xfer   = wb1_valid && wb1_ready;
    assign issue_fire = issue_valid && issue_ready;

    // Clear first, then set: a same-cycle issue to the register being
    // written back re-marks it pending for the newly issued op.
    always_comb begin
        busy_d = busy_q;
        if (wb1_xfer)
            busy_d[wb1_addr] = 1'b0;
        if (issue_fire)
            busy_d[issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= 32'd0;
        else
            busy_q <= busy_d;
    end

    // A register whose writeback lands this cycle is already visible via the
    // write port, so it is reported not busy.
    assign issue_ready = rst || !busy_q[issue_addr];
    assign rs_busy     = !rst && busy_q[rs_addr] && !(wb1_xfer && wb1_addr == rs_addr);
    assign rt_busy     = !rst && busy_q[rt_addr] && !(wb1_xfer && wb1_addr == rt_addr);
`else
    logic unused_sb;
    assign unused_sb   = ^{issue_valid, issue_addr, rs_addr, rt_addr};
    assign issue_ready = 1'b1;
    assign rs_busy     = 1'b0;
    assign rt_busy     = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arb.sv
// Self-checking bench for rf_wb_arb (STARVE_LIMIT=3). Each step drives inputs
// just after a rising edge, pushes the values expected for that cycle, and the
// checker drains the queue at the falling edge.
module tb_rf_wb_arb;

`ifdef RF_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    localparam int S_WB0R = 0, S_WB1R = 1, S_REGW = 2, S_A3 = 3, S_WD = 4,
                   S_IRDY = 5, S_RSB = 6, S_RTB = 7;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb0_valid, wb1_valid, issue_valid;
    logic        wb0_ready, wb1_ready, regw, issue_ready, rs_busy, rt_busy;
    logic [4:0]  wb0_addr, wb1_addr, A3, issue_addr, rs_addr, rt_addr;
    logic [31:0] wb0_data, wb1_data, WD;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];

    rf_wb_arb #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .regw(regw), .A3(A3), .WD(WD),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            S_WB0R:  return {31'd0, wb0_ready};
            S_WB1R:  return {31'd0, wb1_ready};
            S_REGW:  return {31'd0, regw};
            S_A3:    return {27'd0, A3};
            S_WD:    return WD;
            S_IRDY:  return {31'd0, issue_ready};
            S_RSB:   return {31'd0, rs_busy};
            S_RTB:   return {31'd0, rt_busy};
            default: return 32'hx;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, sig_val(e.sig), e.val);
        end
    end

    task automatic ex(input string tag, input int s, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sig = s; e.val = v;
        q.push_back(e);
    endtask

    task automatic ex_wb(input string tag, input bit r0, input bit r1, input bit w,
                         input logic [4:0] a, input logic [31:0] d);
        ex({tag, ".wb0_ready"}, S_WB0R, {31'd0, r0});
        ex({tag, ".wb1_ready"}, S_WB1R, {31'd0, r1});
        ex({tag, ".regw"},      S_REGW, {31'd0, w});
        ex({tag, ".A3"},        S_A3,   {27'd0, a});
        ex({tag, ".WD"},        S_WD,   d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [31:0] d1);
        wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
        wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_addr = 5'd0; rs_addr = 5'd0; rt_addr = 5'd0;
        drv(1, 5'd5, 32'h1111, 1, 5'd6, 32'h2222);
        step();

        // Outputs quiet in reset, issue_ready high.
        for (int i = 0; i < 2; i++) begin
            ex_wb($sformatf("rst%0d", i), 0, 0, 0, 5'd0, 32'd0);
            ex("rst.issue_ready", S_IRDY, 32'd1);
            ex("rst.rs_busy", S_RSB, 32'd0);
            step();
        end

        rst = 1'b0;
        drv(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        ex_wb("idle", 0, 0, 0, 5'd0, 32'd0);
        step();

        drv(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        ex_wb("wb0_only", 1, 0, 1, 5'd5, 32'hDEADBEEF);
        step();

        drv(0, 5'd0, 32'd0, 1, 5'd0, 32'h1234);
        ex_wb("wb1_r0", 0, 1, 0, 5'd0, 32'h1234);
        step();

        drv(0, 5'd0, 32'd0, 1, 5'd17, 32'hCAFE0001);
        ex_wb("wb1_only", 0, 1, 1, 5'd17, 32'hCAFE0001);
        step();

        // Both continuously valid: wb0 x3, forced wb1, wb0 again.
        for (int i = 0; i < 5; i++) begin
            drv(1, 5'd3, 32'h100 + i, 1, 5'd12, 32'hBBBB);
            if (i == 3) ex_wb($sformatf("starve%0d", i), 0, 1, 1, 5'd12, 32'hBBBB);
            else        ex_wb($sformatf("starve%0d", i), 1, 0, 1, 5'd3, 32'h100 + i);
            step();
        end

        // wb1 dropping valid clears the wait count.
        drv(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step();
        for (int i = 0; i < 2; i++) begin
            drv(1, 5'd4, 32'h40 + i, 1, 5'd13, 32'hD0);
            ex_wb($sformatf("pre%0d", i), 1, 0, 1, 5'd4, 32'h40 + i);
            step();
        end
        drv(1, 5'd4, 32'h77, 0, 5'd0, 32'd0);
        ex_wb("gap", 1, 0, 1, 5'd4, 32'h77);
        step();
        for (int i = 0; i < 4; i++) begin
            drv(1, 5'd4, 32'h50 + i, 1, 5'd13, 32'hD0);
            if (i == 3) ex_wb($sformatf("post%0d", i), 0, 1, 1, 5'd13, 32'hD0);
            else        ex_wb($sformatf("post%0d", i), 1, 0, 1, 5'd4, 32'h50 + i);
            step();
        end
        drv(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step();

        // Pending-write scoreboard (expectations collapse to 1/0 when absent).
        issue_valid = 1'b1; issue_addr = 5'd8; rs_addr = 5'd8; rt_addr = 5'd8;
        ex("iss8.issue_ready", S_IRDY, 32'd1);
        ex("iss8.rs_busy", S_RSB, 32'd0);
        step();
        issue_valid = 1'b0;
        ex("busy8.rs_busy", S_RSB, {31'd0, SB});
        ex("busy8.rt_busy", S_RTB, {31'd0, SB});
        step();
        issue_valid = 1'b1;
        ex("waw8.issue_ready", S_IRDY, {31'd0, !SB});
        step();
        issue_valid = 1'b0;
        drv(0, 5'd0, 32'd0, 1, 5'd8, 32'h88);
        ex("ret8.rs_busy", S_RSB, 32'd0);
        ex("ret8.rt_busy", S_RTB, 32'd0);
        ex_wb("ret8", 0, 1, 1, 5'd8, 32'h88);
        step();
        drv(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        ex("after8.issue_ready", S_IRDY, 32'd1);
        ex("after8.rs_busy", S_RSB, 32'd0);
        step();

        // Same-cycle issue and return of r9 leaves it pending.
        issue_valid = 1'b1; issue_addr = 5'd9; rs_addr = 5'd9;
        drv(0, 5'd0, 32'd0, 1, 5'd9, 32'h99);
        ex_wb("same9", 0, 1, 1, 5'd9, 32'h99);
        step();
        issue_valid = 1'b0;
        drv(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        ex("same9.rs_busy", S_RSB, {31'd0, SB});
        step();

        // r0 never becomes busy.
        issue_valid = 1'b1; issue_addr = 5'd0;
        ex("iss0.issue_ready", S_IRDY, 32'd1);
        step();
        issue_valid = 1'b0; rs_addr = 5'd0;
        ex("r0.rs_busy", S_RSB, 32'd0);
        ex("r0.issue_ready", S_IRDY, 32'd1);
        step();

        // Mark r8 busy again, then reset while in FORCE.
        issue_valid = 1'b1; issue_addr = 5'd8; rs_addr = 5'd8;
        step();
        issue_valid = 1'b0;
        ex("rearm8.rs_busy", S_RSB, {31'd0, SB});
        for (int i = 0; i < 3; i++) begin
            drv(1, 5'd2, 32'h60 + i, 1, 5'd14, 32'hE0);
            ex_wb($sformatf("toforce%0d", i), 1, 0, 1, 5'd2, 32'h60 + i);
            step();
        end
        rst = 1'b1;
        ex_wb("rst_force", 0, 0, 0, 5'd0, 32'd0);
        ex("rst_force.rs_busy", S_RSB, 32'd0);
        step();
        rst = 1'b0;
        // Back in NORM with a cleared wait count: wb0 wins three more cycles.
        for (int i = 0; i < 4; i++) begin
            drv(1, 5'd2, 32'h70 + i, 1, 5'd14, 32'hE0);
            if (i == 0) ex("post_rst.rs_busy", S_RSB, 32'd0);
            if (i == 3) ex_wb($sformatf("post_rst%0d", i), 0, 1, 1, 5'd14, 32'hE0);
            else        ex_wb($sformatf("post_rst%0d", i), 1, 0, 1, 5'd2, 32'h70 + i);
            step();
        end
        drv(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        ex_wb("end_idle", 0, 0, 0, 5'd0, 32'd0);
        step();
        step();

        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Hard stop so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule
